// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================
// mdu_ctrl_pkg : shared MD opcode and FSM state encodings
// Rev 1.0
// ============================================================
package mdu_ctrl_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  // Ops that occupy the unit for a busy period
  function automatic logic is_arith(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_arith.sv
`default_nettype none
// ============================================================
// mdu_ctrl_arith : combinational {HI,LO} result for mult/multu/div/divu
// Rev 1.0
// ============================================================
module mdu_ctrl_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic [31:0] w_den;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [31:0] w_q;
  logic [31:0] w_r;

  always_comb begin
    result  = '0;
    // Divisor forced non-zero; the caller discards the result when b==0
    w_den   = (b == 32'd0) ? 32'd1 : b;
    w_mag_a = a[31] ? (32'd0 - a) : a;
    w_mag_b = w_den[31] ? (32'd0 - w_den) : w_den;
    w_q     = w_mag_a / w_mag_b;
    w_r     = w_mag_a % w_mag_b;
    case (md_op)
      MD_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MD_MULTU: result = {32'd0, a} * {32'd0, b};
      MD_DIV:   result = {(a[31] ? (32'd0 - w_r) : w_r),
                          ((a[31] ^ w_den[31]) ? (32'd0 - w_q) : w_q)};
      MD_DIVU:  result = {a % w_den, a / w_den};
      default:  result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================
// mdu_ctrl : HI/LO owner with fixed-latency mult/div sequencing and D-stall
// Rev 1.0
// ============================================================
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CW = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_pend;
  logic          r_pend_wr;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [63:0]   w_result;

  mdu_ctrl_arith u_arith (
    .md_op  (md_op),
    .a      (a),
    .b      (b),
    .result (w_result)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_pend_wr <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                r_pend    <= w_result;
                r_pend_wr <= 1'b1;
                r_cnt     <= CW'(MULT_CYCLES);
                r_state   <= S_MUL;
              end
              MD_DIV, MD_DIVU: begin
                r_pend    <= w_result;
                r_pend_wr <= (b != 32'd0);
                r_cnt     <= CW'(DIV_CYCLES);
                r_state   <= S_DIV;
              end
              MD_MTHI: r_hi <= a;
              MD_MTLO: r_lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          // Issue is ignored here; the D-stage stall keeps it from happening legally
          if (r_cnt <= CW'(1)) begin
            if (r_pend_wr) begin
              r_hi <= r_pend[63:32];
              r_lo <= r_pend[31:0];
            end
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign stall  = d_is_md & (busy | (start & is_arith(md_op)));
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================
// tb_mdu_ctrl : scoreboard bench for mdu_ctrl against a behavioural HI/LO model
// Rev 1.0
// ============================================================
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        d_is_md = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  exp_t        sb[$];

  mdu_ctrl #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .a       (a),
    .b       (b),
    .d_is_md (d_is_md),
    .busy    (busy),
    .stall   (stall),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural result from the instruction set rules; returns {HI,LO}
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] h,
                                         input logic [31:0] l);
    int          sx;
    int          sy;
    logic [63:0] p;
    sx = x;
    sy = y;
    p  = {h, l};
    case (op)
      3'd1: p = longint'(sx) * longint'(sy);
      3'd2: p = {32'd0, x} * {32'd0, y};
      3'd3: if (y != 0) p = {32'(sx % sy), 32'(sx / sy)};
      3'd4: if (y != 0) p = {x % y, x / y};
      default: ;
    endcase
    return p;
  endfunction

  // Monitor: every busy->idle transition retires one scoreboard entry
  exp_t mon_e;
  int   bcnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (busy === 1'b1) bcnt++;
    if (prev_busy && busy === 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_completion", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_hi", {32'd0, hi_out}, {32'd0, mon_e.hi});
        check("done_lo", {32'd0, lo_out}, {32'd0, mon_e.lo});
        check("busy_len", 64'(bcnt), 64'(mon_e.len));
      end
      bcnt = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  task automatic launch(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        input logic d);
    exp_t        e;
    logic [63:0] r;
    logic        arith;
    @(negedge clk);
    start   = 1'b1;
    md_op   = op;
    a       = aa;
    b       = bb;
    d_is_md = d;
    arith   = (op >= 3'd1) && (op <= 3'd4);
    #1 check("stall_issue", {63'd0, stall}, {63'd0, d & arith});
    if (arith) begin
      r     = ref_op(op, aa, bb, m_hi, m_lo);
      e.hi  = r[63:32];
      e.lo  = r[31:0];
      e.len = (op <= 3'd2) ? MULT_LAT : DIV_LAT;
      sb.push_back(e);
      m_hi  = e.hi;
      m_lo  = e.lo;
    end else if (op == 3'd5) begin
      m_hi = aa;
    end else if (op == 3'd6) begin
      m_lo = aa;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) check("busy_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic release_wait();
    @(negedge clk);
    start   = 1'b0;
    md_op   = 3'd0;
    d_is_md = 1'b0;
    wait_idle();
  endtask

  task automatic op_full(input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb,
                         input logic d);
    launch(op, aa, bb, d);
    release_wait();
    check("idle_hi", {32'd0, hi_out}, {32'd0, m_hi});
    check("idle_lo", {32'd0, lo_out}, {32'd0, m_lo});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    exp_t        e;
    logic [2:0]  op;
    logic [31:0] aa;
    logic [31:0] bb;

    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hi", {32'd0, hi_out}, 64'd0);
    check("rst_lo", {32'd0, lo_out}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_stall", {63'd0, stall}, 64'd0);

    op_full(MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
    check("mult_hi_k", {32'd0, hi_out}, 64'hFFFFFFFF);
    check("mult_lo_k", {32'd0, lo_out}, 64'hFFFFFFEB);
    op_full(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_hi_k", {32'd0, hi_out}, 64'hFFFFFFFE);
    check("multu_lo_k", {32'd0, lo_out}, 64'h00000001);
    op_full(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_hi_k", {32'd0, hi_out}, 64'hFFFFFFFF);
    check("div_lo_k", {32'd0, lo_out}, 64'hFFFFFFFD);
    op_full(MD_DIVU, 32'd7, 32'd2, 1'b0);
    check("divu_hi_k", {32'd0, hi_out}, 64'd1);
    check("divu_lo_k", {32'd0, lo_out}, 64'd3);

    // Hazard window with d_is_md held high
    launch(MD_DIV, 32'd100, 32'd7, 1'b1);
    for (int i = 1; i <= DIV_LAT; i++) begin
      @(negedge clk);
      start = 1'b0;
      md_op = 3'd0;
      check("stall_busy", {63'd0, stall}, 64'd1);
    end
    @(negedge clk);
    check("stall_after", {63'd0, stall}, 64'd0);
    d_is_md = 1'b0;
    wait_idle();

    launch(MD_DIVU, 32'd1000, 32'd9, 1'b0);
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    check("stall_no_d", {63'd0, stall}, 64'd0);
    check("busy_no_d", {63'd0, busy}, 64'd1);
    wait_idle();

    // Divide by zero leaves HI/LO alone
    op_full(MD_MTHI, 32'h11, 32'd0, 1'b0);
    op_full(MD_MTLO, 32'h22, 32'd0, 1'b0);
    op_full(MD_DIV, 32'd5, 32'd0, 1'b0);
    check("dz_hi_k", {32'd0, hi_out}, 64'h11);
    check("dz_lo_k", {32'd0, lo_out}, 64'h22);

    // Mult issued while a div is running must be dropped
    launch(MD_DIV, 32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    md_op = MD_MULT;
    a     = 32'd9;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    wait_idle();
    @(negedge clk);
    check("ign_busy", {63'd0, busy}, 64'd0);
    check("ign_hi", {32'd0, hi_out}, 64'd1);
    check("ign_lo", {32'd0, lo_out}, 64'd333);

    // Reset during busy cycle 4 of a div discards the result
    launch(MD_DIV, 32'hFFFF, 32'h10, 1'b0);
    void'(sb.pop_back());
    e.hi  = '0;
    e.lo  = '0;
    e.len = 4;
    sb.push_back(e);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_hi", {32'd0, hi_out}, 64'd0);
    check("mrst_lo", {32'd0, lo_out}, 64'd0);
    op_full(MD_MTHI, 32'h1234, 32'd0, 1'b0);
    check("mthi_k", {32'd0, hi_out}, 64'h1234);
    check("mthi_lo_k", {32'd0, lo_out}, 64'd0);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      aa = $urandom;
      if ($urandom_range(0, 3) == 0) aa = 32'($urandom_range(0, 40)) - 32'd20;
      bb = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      if ($urandom_range(0, 3) == 0) bb = 32'($urandom_range(0, 10)) - 32'd5;
      if (aa == 32'h80000000 && bb == 32'hFFFFFFFF) bb = 32'd1;
      op_full(op, aa, bb, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline. It owns HI/LO and accepts mult/multu/div/divu/mthi/mtlo issued from the E stage. It sequences the fixed operation latency with a busy counter and raises the stall request that holds MD-type instructions in D. mfhi/mflo read hi_out/lo_out directly.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low; reset==0 at a rising edge clears all state
start  input  1  E-stage MD instruction valid this cycle
md_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
a  input  32  rs operand (E stage, already forwarded)
b  input  32  rt operand (E stage, already forwarded)
d_is_md  input  1  D-stage instruction is any MD-type (incl. mfhi/mflo)
busy  output  1  operation in progress
stall  output  1  freeze PC/F/D, insert bubble into E
hi_out  output  32  current HI
lo_out  output  32  current LO

Behaviour:
- Reset (reset==0 at edge): state IDLE, counter 0, HI=LO=0, result registers 0; busy=0. Applies mid-operation: an in-flight result is discarded.
- FSM states: IDLE, MUL_RUN, DIV_RUN.
- IDLE, start=1, op MULT/MULTU at edge t: operands latched, product computed into 64-bit pending register. Go to MUL_RUN with cnt=MULT_CYCLES. busy=1 during cycles t+1..t+MULT_CYCLES.
- DIV/DIVU: same pattern with DIV_CYCLES. Go to DIV_RUN.
- RUN states: cnt decrements each edge. At the edge ending the last busy cycle, HI/LO take the pending value and state returns to IDLE. New HI/LO are visible and busy=0 from cycle t+N+1.
- Arithmetic:
  - MULT: signed 32x32 to 64, {HI,LO}.
  - MULTU: unsigned.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned.
  - b==0 on DIV/DIVU: full busy period still runs, but HI/LO are left unchanged.
- MTHI/MTLO in IDLE: HI (or LO) <= a at that edge, visible next cycle. No busy.
- start while busy (any op): ignored. stall guarantees this cannot occur legally.
- md_op NONE/reserved with start=1: no effect.
- stall = d_is_md & (busy | (start & md_op in {MULT,MULTU,DIV,DIVU})). Combinational.
- busy is a registered output (state != IDLE). hi_out/lo_out are registered values.
- Same-cycle MTHI and completion are impossible: the issue is ignored while busy.

Decomposition:
- Shared package/header holds the md_op encodings (MD_NONE..MD_MTLO) and state encodings (S_IDLE, S_MUL, S_DIV).
- No sub-module required. Optional mdu_arith (combinational 64-bit product/quotient/remainder) may be split out for reuse by a later iterative divider.

Test Plan:
- mult a=0xFFFFFFFD b=7 at t -> busy=1 for t+1..t+5; from t+6 hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB.
- multu a=b=0xFFFFFFFF -> after 5 busy cycles hi_out=0xFFFFFFFE, lo_out=0x00000001. Then div a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles, then lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Then divu 7/2 -> lo_out=3, hi_out=1.
- Hazard: d_is_md=1 held from cycle t of a div -> stall=1 for cycles t..t+10, stall=0 at t+11. d_is_md=0 while busy -> stall=0.
- Divide by zero: mthi 0x11, mtlo 0x22, then div a=5 b=0 -> busy 10 cycles, hi_out=0x11, lo_out=0x22 afterwards.
- Ignored issue: start mult while busy from a div -> HI/LO equal the div result only; busy drops on schedule.
- reset=0 for one edge at busy cycle 4 of a div -> next cycle busy=0, hi_out=lo_out=0. Then mthi a=0x1234 -> hi_out=0x1234 next cycle, lo_out stays 0.
